boot_controller: RTL

- Boot sequencer for the iZero CPU. After reset the CPU fetches from the BIOS ROM.
- When the BIOS executes halt, this block copies a program of prog_len words from the HD, starting at HD word 0, into instruction memory at address 0.
- It then pulses a PC clear and switches instruction fetch to instruction memory.
- It sits between the PC/fetch stage, the BIOS ROM, instruction memory and the HD interface.

---
 rtl/boot_controller_if.sv | 12 +
 rtl/boot_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/boot_controller_if.sv
// HD read channel between the boot controller (master) and the disk interface (slave).
interface boot_controller_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              hd_req;
    logic [ADDR_W-1:0] hd_addr;
    logic              hd_ack;
    logic [31:0]       hd_data;

    modport master (output hd_req, output hd_addr, input hd_ack, input hd_data);
    modport slave  (input hd_req, input hd_addr, output hd_ack, output hd_data);
endinterface

// File: rtl/boot_controller.sv
// Boot sequencer: runs the BIOS, copies prog_len HD words into instruction memory on halt,
// then restarts the CPU from imem. Optional HD ack timeout enabled by macro BOOT_TIMEOUT_EN.
module boot_controller #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [31:0]       bios_instr,
    input  logic [31:0]       imem_instr,
    output logic [31:0]       instrucao,
    output logic              cpu_stall,
    output logic              cpu_reset_pc,
    boot_controller_if.master hd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              boot_done,
    output logic              boot_error
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("boot_controller: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_BIOS, S_REQ, S_WRITE, S_START, S_USER, S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               cpu_stall_q, cpu_stall_d;
    logic               cpu_reset_pc_q, cpu_reset_pc_d;
    logic               hd_req_q, hd_req_d;
    logic [ADDR_W-1:0]  hd_addr_q, hd_addr_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               boot_done_q, boot_done_d;

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               boot_error_q, boot_error_d;
`endif

    // Next state, copy bookkeeping and output decode of the upcoming state.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        len_d        = len_q;
        imem_wdata_d = imem_wdata_q;

        unique case (state_q)
            S_BIOS: begin
                if (halt) begin
                    len_d     = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                    counter_d = '0;
                    state_d   = (prog_len == '0) ? S_START : S_REQ;
                end
            end
            S_REQ: begin
                if (hd.hd_ack) begin
                    imem_wdata_d = hd.hd_data;
                    state_d      = S_WRITE;
                end
`ifdef BOOT_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_WRITE: begin
                counter_d = counter_q + CNT_W'(1);
                state_d   = (counter_d == len_q) ? S_START : S_REQ;
            end
            S_START:       state_d = S_USER;
            S_USER, S_ERR: state_d = state_q;
            default:       state_d = S_BIOS;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        cpu_stall_d    = (state_d == S_REQ) || (state_d == S_WRITE) ||
                         (state_d == S_START) || (state_d == S_ERR);
        cpu_reset_pc_d = (state_d == S_START);
        hd_req_d       = (state_d == S_REQ);
        hd_addr_d      = hd_req_d ? counter_d[ADDR_W-1:0] : '0;
        imem_we_d      = (state_d == S_WRITE);
        imem_addr_d    = imem_we_d ? counter_d[ADDR_W-1:0] : imem_addr_q;
        boot_done_d    = (state_d == S_USER);

`ifdef BOOT_TIMEOUT_EN
        wait_d       = ((state_q == S_REQ) && (state_d == S_REQ)) ? wait_q + WAIT_W'(1) : '0;
        boot_error_d = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_BIOS;
            counter_q      <= '0;
            len_q          <= '0;
            cpu_stall_q    <= 1'b0;
            cpu_reset_pc_q <= 1'b0;
            hd_req_q       <= 1'b0;
            hd_addr_q      <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            boot_done_q    <= 1'b0;
`ifdef BOOT_TIMEOUT_EN
            wait_q         <= '0;
            boot_error_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            len_q          <= len_d;
            cpu_stall_q    <= cpu_stall_d;
            cpu_reset_pc_q <= cpu_reset_pc_d;
            hd_req_q       <= hd_req_d;
            hd_addr_q      <= hd_addr_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            boot_done_q    <= boot_done_d;
`ifdef BOOT_TIMEOUT_EN
            wait_q         <= wait_d;
            boot_error_q   <= boot_error_d;
`endif
        end
    end

    // Fetch source switches away from the BIOS as soon as the copy starts.
    assign instrucao    = (state_q == S_BIOS) ? bios_instr : imem_instr;
    assign cpu_stall    = cpu_stall_q;
    assign cpu_reset_pc = cpu_reset_pc_q;
    assign hd.hd_req    = hd_req_q;
    assign hd.hd_addr   = hd_addr_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign boot_done    = boot_done_q;
`ifdef BOOT_TIMEOUT_EN
    assign boot_error   = boot_error_q;
`else
    assign boot_error   = 1'b0;
`endif

endmodule
